// File: rtl/chunked_add_sequencer_if.sv
// Purpose: request/result handshake bundle for the chunked add/subtract sequencer.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the result side.
interface chunked_add_sequencer_if #(
    parameter int W = 16
);
    logic         i_Valid;
    logic         o_Ready;
    logic [W-1:0] i_A;
    logic [W-1:0] i_B;
    logic         i_Sub;
    logic         i_Cin;
    logic         o_Valid;
    logic         i_Ready;
    logic [W-1:0] o_Sum;
    logic         o_Cout;
    logic         o_Ovf;
    logic         o_Busy;

    // Requester / result consumer side
    modport master (
        output i_Valid, i_A, i_B, i_Sub, i_Cin, i_Ready,
        input  o_Ready, o_Valid, o_Sum, o_Cout, o_Ovf, o_Busy
    );

    // Sequencer side
    modport slave (
        input  i_Valid, i_A, i_B, i_Sub, i_Cin, i_Ready,
        output o_Ready, o_Valid, o_Sum, o_Cout, o_Ovf, o_Busy
    );
endinterface

// File: rtl/chunked_add_sequencer.sv
// Purpose: W-bit add/subtract done one CHUNK_W slice per cycle through one shared ripple adder.
// Latency: o_Valid rises NUM_CHUNKS edges after the accept edge; one op in flight.
// Backpressure: o_Ready only in IDLE; the result is held in DONE until i_Ready.

// Plain ripple-carry adder; the only arithmetic in the sequencer.
module RippleCarryAdder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = i_Cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign o_Sum[g]  = i_A[g] ^ i_B[g] ^ w_c[g];
        assign w_c[g+1]  = (i_A[g] & i_B[g]) | (w_c[g] & (i_A[g] ^ i_B[g]));
    end

    assign o_Cout = w_c[WIDTH];
endmodule

module chunked_add_sequencer #(
    parameter int CHUNK_W    = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    chunked_add_sequencer_if.slave bus
);
    localparam int W  = CHUNK_W * NUM_CHUNKS;
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;      // already inverted for subtract
    logic [W-1:0]   r_sum;
    logic           r_ovf;

    logic [CHUNK_W-1:0] w_a_chunk;
    logic [CHUNK_W-1:0] w_b_chunk;
    logic [CHUNK_W-1:0] w_sum_chunk;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;

    assign w_accept  = (r_state == IDLE) && bus.i_Valid;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_chunk = r_a[int'(r_idx)*CHUNK_W +: CHUNK_W];
    assign w_b_chunk = r_b[int'(r_idx)*CHUNK_W +: CHUNK_W];

    RippleCarryAdder #(.WIDTH(CHUNK_W)) u_rca (
        .i_A    (w_a_chunk),
        .i_B    (w_b_chunk),
        .i_Cin  (r_carry),
        .o_Sum  (w_sum_chunk),
        .o_Cout (w_cout)
    );

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode: accept in IDLE, walk chunks in RUN, hold in DONE until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_Valid)  w_next = RUN;
            RUN:     if (w_last)       w_next = DONE;
            DONE:    if (bus.i_Ready)  w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    // Operand latch on accept, then one chunk of sum and the carry per RUN cycle
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.i_A;
            r_b     <= bus.i_Sub ? ~bus.i_B : bus.i_B;
            r_carry <= bus.i_Sub ? 1'b1 : bus.i_Cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[int'(r_idx)*CHUNK_W +: CHUNK_W] <= w_sum_chunk;
            r_carry <= w_cout;
            if (w_last) begin
                // Signed overflow: like-signed operands producing a differently-signed result
                r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_sum_chunk[CHUNK_W-1] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.o_Ready = (r_state == IDLE);
    assign bus.o_Valid = (r_state == DONE);
    assign bus.o_Busy  = (r_state != IDLE);
    assign bus.o_Sum   = r_sum;
    assign bus.o_Cout  = r_carry;
    assign bus.o_Ovf   = r_ovf;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Purpose: directed checks of the chunked add/subtract sequencer (W=16, 4x4-bit chunks).
// Latency: expects o_Valid exactly 4 edges after the accept edge.
// Backpressure: exercises held results under i_Ready=0 and ignored requests outside IDLE.
module tb_chunked_add_sequencer;
    logic i_Clk = 1'b0;
    logic i_Rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    chunked_add_sequencer_if #(.W(16)) bus ();

    chunked_add_sequencer #(.CHUNK_W(4), .NUM_CHUNKS(4)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .bus     (bus)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for its result, check it, then let it be taken.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input logic scramble,
                         input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
        int n;
        @(negedge i_Clk);
        chk({tag, "_ready_before"}, 32'(bus.o_Ready), 32'd1);
        bus.i_Valid = 1'b1;
        bus.i_A = a; bus.i_B = b; bus.i_Sub = sub; bus.i_Cin = cin;
        bus.i_Ready = 1'b0;
        @(posedge i_Clk);           // accept edge
        #1;
        bus.i_Valid = 1'b0;
        n = 0;
        do begin
            @(posedge i_Clk);
            #1;
            n++;
            if (scramble) begin
                bus.i_A   = 16'($urandom);
                bus.i_B   = 16'($urandom);
                bus.i_Sub = 1'($urandom);
                bus.i_Cin = 1'($urandom);
            end
        end while (!bus.o_Valid && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_sum"},  32'(bus.o_Sum),  32'(e_sum));
        chk({tag, "_cout"}, 32'(bus.o_Cout), 32'(e_cout));
        chk({tag, "_ovf"},  32'(bus.o_Ovf),  32'(e_ovf));
        chk({tag, "_ready_done"}, 32'(bus.o_Ready), 32'd0);
        @(negedge i_Clk);
        bus.i_Ready = 1'b1;
        @(posedge i_Clk);
        #1;
        bus.i_Ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(bus.o_Valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(bus.o_Ready), 32'd1);
        chk({tag, "_idle_sum"},   32'(bus.o_Sum),   32'(e_sum));
    endtask

    initial begin
        bus.i_Valid = 1'b0; bus.i_A = '0; bus.i_B = '0;
        bus.i_Sub = 1'b0; bus.i_Cin = 1'b0; bus.i_Ready = 1'b0;
        i_Rst_n = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.o_Valid), 32'd0);
        chk("rst_ready", 32'(bus.o_Ready), 32'd1);
        chk("rst_busy",  32'(bus.o_Busy),  32'd0);
        chk("rst_sum",   32'(bus.o_Sum),   32'd0);
        chk("rst_cout",  32'(bus.o_Cout),  32'd0);
        chk("rst_ovf",   32'(bus.o_Ovf),   32'd0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;

        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_cin1",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op("isolate",   16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0);

        // Backpressure: result held while i_Ready=0, new requests refused
        @(negedge i_Clk);
        bus.i_Valid = 1'b1; bus.i_A = 16'h1111; bus.i_B = 16'h2222;
        bus.i_Sub = 1'b0; bus.i_Cin = 1'b0; bus.i_Ready = 1'b0;
        @(posedge i_Clk);
        #1;
        bus.i_Valid = 1'b0;
        repeat (4) @(posedge i_Clk);
        #1;
        chk("bp_valid_rise", 32'(bus.o_Valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_Clk);
            bus.i_Valid = 1'b1; bus.i_A = 16'h0001 + 16'(k); bus.i_B = 16'h0001;
            @(posedge i_Clk);
            #1;
            chk("bp_valid", 32'(bus.o_Valid), 32'd1);
            chk("bp_ready", 32'(bus.o_Ready), 32'd0);
            chk("bp_sum",   32'(bus.o_Sum),   32'h3333);
        end
        @(negedge i_Clk);
        bus.i_Valid = 1'b0;
        bus.i_Ready = 1'b1;
        @(posedge i_Clk);
        #1;
        bus.i_Ready = 1'b0;
        chk("bp_release_ready", 32'(bus.o_Ready), 32'd1);
        chk("bp_release_busy",  32'(bus.o_Busy),  32'd0);
        do_op("bp_next",   16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

        // Reset abort while idx==2
        @(negedge i_Clk);
        bus.i_Valid = 1'b1; bus.i_A = 16'h1234; bus.i_B = 16'h1111;
        bus.i_Sub = 1'b0; bus.i_Cin = 1'b0;
        @(posedge i_Clk);
        #1;
        bus.i_Valid = 1'b0;
        repeat (2) @(posedge i_Clk);
        #2;
        chk("abort_busy_before", 32'(bus.o_Busy), 32'd1);
        i_Rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.o_Valid), 32'd0);
        chk("abort_busy",  32'(bus.o_Busy),  32'd0);
        chk("abort_ready", 32'(bus.o_Ready), 32'd1);
        chk("abort_sum",   32'(bus.o_Sum),   32'd0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
